// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, divider
// sequencer states, and the constants used for RV32M corner cases.
package mdu_pkg;

  localparam int MDU_XLEN        = 32;
  localparam int DIV_LAT_DEFAULT = 33;

  localparam logic [MDU_XLEN-1:0] INT_MIN  = 32'h8000_0000;
  localparam logic [MDU_XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE
  } div_state_e;

endpackage

// File: rtl/div_ctrl_if.sv
// EXU-side request/response handshake of the divide sequencer.
interface div_ctrl_if;
  import mdu_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [1:0]          in_op;
  logic [MDU_XLEN-1:0] in_src1;
  logic [MDU_XLEN-1:0] in_src2;
  logic                out_valid;
  logic                out_ready;
  logic [MDU_XLEN-1:0] out_result;

  modport master (
    output in_valid, in_op, in_src1, in_src2, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_op, in_src1, in_src2, out_ready,
    output in_ready, out_valid, out_result
  );

endinterface

// File: rtl/div_ctrl.sv
// Sequencer between the EXU and the unsigned iterative divider: sign handling,
// divide-by-zero / overflow short-cuts, and rejection of a stale divider done flag.
module div_ctrl
  import mdu_pkg::*;
#(
  parameter int DIV_LAT = DIV_LAT_DEFAULT,
  parameter int XLEN    = MDU_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  div_ctrl_if.slave       req,
  output logic [XLEN-1:0] div_dividend,
  output logic [XLEN-1:0] div_divisor,
  output logic            div_valid,
  input  logic [XLEN-1:0] div_q,
  input  logic [XLEN-1:0] div_r,
  input  logic            div_out_valid
);

  localparam logic [5:0] LAT_THR = 6'(DIV_LAT);
  localparam logic [5:0] LAT_MAX = 6'd63;

  div_state_e      state_reg, state_next;
  div_op_e         op_reg;
  logic            s1_reg, s2_reg;
  logic [XLEN-1:0] dividend_reg, divisor_reg, result_reg;
  logic [5:0]      lat_cnt_reg;
  logic            out_valid_reg, div_valid_reg;

  div_op_e         in_op;
  logic            in_ready_int, accept, in_signed, in_s1, in_s2, in_special, capture;
  logic [XLEN-1:0] in_mag1, in_mag2, special_result, cap_result;

  always_comb begin
    in_op          = div_op_e'(req.in_op);
    in_ready_int   = (state_reg == S_IDLE) && !flush;
    accept         = req.in_valid && in_ready_int;
    in_signed      = (in_op == OP_DIV) || (in_op == OP_REM);
    in_s1          = in_signed && req.in_src1[XLEN-1];
    in_s2          = in_signed && req.in_src2[XLEN-1];
    in_mag1        = in_s1 ? -req.in_src1 : req.in_src1;
    in_mag2        = in_s2 ? -req.in_src2 : req.in_src2;
    // Divide-by-zero and INT_MIN / -1 never reach the divider.
    in_special     = (req.in_src2 == '0) ||
                     (in_signed && req.in_src1 == INT_MIN && req.in_src2 == ALL_ONES);
    special_result = '0;
    if (req.in_src2 == '0)
      special_result = req.in_op[1] ? req.in_src1 : ALL_ONES;
    else
      special_result = req.in_op[1] ? '0 : INT_MIN;
  end

  // A done flag seen before the divider can possibly be finished is stale.
  assign capture = (state_reg == S_WAIT) && (lat_cnt_reg >= LAT_THR) && div_out_valid;

  always_comb begin
    cap_result = div_r;
    case (op_reg)
      OP_DIV:  cap_result = (s1_reg ^ s2_reg) ? -div_q : div_q;
      OP_DIVU: cap_result = div_q;
      OP_REM:  cap_result = s1_reg ? -div_r : div_r;
      default: cap_result = div_r;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept) state_next = in_special ? S_DONE : S_START;
      S_START: state_next = S_WAIT;
      S_WAIT:  if (capture) state_next = S_DONE;
      S_DONE:  if (req.out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (flush) state_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg        <= OP_DIV;
      s1_reg        <= 1'b0;
      s2_reg        <= 1'b0;
      dividend_reg  <= '0;
      divisor_reg   <= '0;
      result_reg    <= '0;
      lat_cnt_reg   <= '0;
      out_valid_reg <= 1'b0;
      div_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= (state_next == S_DONE);
      div_valid_reg <= (state_next == S_START);
      if (accept) begin
        op_reg       <= in_op;
        s1_reg       <= in_s1;
        s2_reg       <= in_s2;
        dividend_reg <= in_mag1;
        divisor_reg  <= in_mag2;
        if (in_special) result_reg <= special_result;
      end
      if (state_reg == S_START)
        lat_cnt_reg <= 6'd1;
      else if (state_reg == S_WAIT && lat_cnt_reg != LAT_MAX)
        lat_cnt_reg <= lat_cnt_reg + 6'd1;
      if (capture && !flush) result_reg <= cap_result;
    end
  end

  assign req.in_ready   = in_ready_int;
  assign req.out_valid  = out_valid_reg;
  assign req.out_result = result_reg;
  assign div_dividend   = dividend_reg;
  assign div_divisor    = divisor_reg;
  assign div_valid      = div_valid_reg;

endmodule

// File: tb/tb_div_ctrl.sv
// Randomized and directed check of div_ctrl against an arithmetic reference,
// with a behavioural divider whose done flag can stick high or arrive late.
module tb_div_ctrl;

  localparam int DIV_LAT = 33;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic [31:0] div_dividend, div_divisor, div_q, div_r;
  logic div_valid, div_out_valid;

  int n_assert = 0;
  int n_fail = 0;

  div_ctrl_if bus ();

  div_ctrl #(.DIV_LAT(DIV_LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .req          (bus),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_valid    (div_valid),
    .div_q        (div_q),
    .div_r        (div_r),
    .div_out_valid(div_out_valid)
  );

  always #5 clk = ~clk;

  // Behavioural divider: result final DIV_LAT cycles after start; done flag is
  // either left stuck high from earlier or raised DIV_LAT+extra cycles after start.
  logic        cfg_stuck = 1'b1;
  int          cfg_extra = 0;
  int          m_cnt = 0;
  int          m_extra = 0;
  logic        m_stuck = 1'b1;
  logic [31:0] m_a = 32'd0;
  logic [31:0] m_b = 32'd1;
  logic [31:0] m_bs;
  logic        m_done;

  always @(posedge clk) begin
    if (div_valid) begin
      m_a     <= div_dividend;
      m_b     <= div_divisor;
      m_cnt   <= 1;
      m_extra <= cfg_extra;
      m_stuck <= cfg_stuck;
    end else begin
      if (m_cnt > 0 && m_cnt < 200) m_cnt <= m_cnt + 1;
      if (m_done) m_stuck <= 1'b1;
    end
  end

  assign m_bs          = (m_b == 32'd0) ? 32'd1 : m_b;
  assign m_done        = (m_cnt >= DIV_LAT + m_extra);
  assign div_out_valid = m_stuck | m_done;
  assign div_q         = (m_cnt >= DIV_LAT) ? (m_a / m_bs) : ~(m_a / m_bs);
  assign div_r         = (m_cnt >= DIV_LAT) ? (m_a % m_bs) : ~(m_a % m_bs);

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) return (op == 2'b10 || op == 2'b11) ? a : 32'hFFFF_FFFF;
    case (op)
      2'b00:   return 32'(sa / sb);
      2'b01:   return a / b;
      2'b10:   return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      4:       return 32'd0 - 32'($urandom_range(1, 20));
      default: return 32'($urandom());
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input logic stuck, input int extra);
    logic [31:0] exp_res, exp_m1, exp_m2;
    logic        special, signed_op;
    int          exp_lat, n, pulses, first_pulse;
    bit          done;
    exp_res   = ref_div(op, a, b);
    signed_op = (op == 2'b00) || (op == 2'b10);
    special   = (b == 32'd0) || (signed_op && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    exp_m1    = (signed_op && a[31]) ? 32'd0 - a : a;
    exp_m2    = (signed_op && b[31]) ? 32'd0 - b : b;
    exp_lat   = special ? 1 : (stuck ? DIV_LAT + 2 : DIV_LAT + 2 + extra);

    @(negedge clk);
    flush         = 1'b0;
    cfg_stuck     = stuck;
    cfg_extra     = extra;
    bus.in_op     = op;
    bus.in_src1   = a;
    bus.in_src2   = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    #1;
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;

    n = 0; pulses = 0; first_pulse = 0; done = 0;
    while (!done && n < 120) begin
      @(negedge clk);
      n++;
      if (div_valid) begin
        pulses++;
        if (first_pulse == 0) first_pulse = n;
        check("div_dividend", div_dividend, exp_m1);
        check("div_divisor", div_divisor, exp_m2);
      end
      if (bus.out_valid) done = 1;
    end
    check("timeout", 32'(done), 32'd1);
    check("latency", 32'(n), 32'(exp_lat));
    check("div_pulses", 32'(pulses), special ? 32'd0 : 32'd1);
    if (!special) check("div_pulse_cycle", 32'(first_pulse), 32'd1);
    check("result", bus.out_result, exp_res);

    for (int i = 0; i < hold; i++) begin
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_result", bus.out_result, exp_res);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    check("handshake_valid", 32'(bus.out_valid), 32'd1);
    check("handshake_result", bus.out_result, exp_res);
    @(negedge clk);
    check("after_valid", 32'(bus.out_valid), 32'd0);
    check("after_in_ready", 32'(bus.in_ready), 32'd1);
    $display("op=%0d a=%h b=%h result=%h expected=%h latency=%0d hold=%0d stuck=%0d extra=%0d",
             op, a, b, bus.out_result, exp_res, n, hold, stuck, extra);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'b00;
    bus.in_src1   = 32'd0;
    bus.in_src2   = 32'd0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_div_valid", 32'(div_valid), 32'd0);
    check("rst_out_result", bus.out_result, 32'd0);
    check("rst_dividend", div_dividend, 32'd0);
    check("rst_divisor", div_divisor, 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;

    // Directed corner cases
    run_op(2'b00, 32'd100, 32'hFFFF_FFF9, 0, 1'b1, 0);
    run_op(2'b10, 32'd100, 32'hFFFF_FFF9, 0, 1'b0, 3);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd0, 0, 1'b1, 0);
    run_op(2'b10, 32'hFFFF_FFFB, 32'd0, 0, 1'b1, 0);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1, 0);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1, 0);
    run_op(2'b00, 32'hFFFF_FF9C, 32'd7, 5, 1'b1, 0);

    // Flush in WAIT at lat_cnt=10, then restart; stale done flag must be ignored
    @(negedge clk);
    cfg_stuck     = 1'b0;
    cfg_extra     = 0;
    bus.in_op     = 2'b01;
    bus.in_src1   = 32'hFFFF_0000;
    bus.in_src2   = 32'd3;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (11) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_in_ready", 32'(bus.in_ready), 32'd0);
    run_op(2'b01, 32'd50, 32'd7, 0, 1'b1, 0);

    // Randomized operations
    for (int t = 0; t < 40; t++) begin
      run_op(2'($urandom_range(0, 3)), pick(), pick(), $urandom_range(0, 2),
             1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    // Asynchronous reset in the middle of WAIT
    @(negedge clk);
    bus.in_op    = 2'b01;
    bus.in_src1  = 32'd1000;
    bus.in_src2  = 32'd3;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_div_valid", 32'(div_valid), 32'd0);
    check("mid_rst_out_result", bus.out_result, 32'd0);
    check("mid_rst_dividend", div_dividend, 32'd0);
    check("mid_rst_divisor", div_divisor, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (40) @(negedge clk);
    check("post_rst_no_result", 32'(bus.out_valid), 32'd0);
    run_op(2'b00, 32'd100, 32'hFFFF_FFF9, 1, 1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencer between the EXU and the unsigned 32-cycle iterative divider `div`.
- Accepts RV32M DIV/DIVU/REM/REMU requests over a valid/ready handshake.
- Converts signed operands to magnitudes, launches the divider, and fixes the result sign.
- Resolves divide-by-zero and signed overflow without using the divider.
- Guards against the divider's level-held, unreset `out_valid`.

Parameters:
- DIV_LAT, 33: cycles from the `div_valid` cycle to the first cycle in which `div` q/r are final.
- XLEN, 32: operand width. Only 32 is supported.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- in_src1  in  32  dividend
- in_src2  in  32  divisor
- flush  in  1  synchronous abort, highest priority
- out_valid  out  1  result valid; held until out_ready
- out_ready  in  1  consumer ready
- out_result  out  32  quotient or remainder
- div_dividend  out  32  divider dividend; registered magnitude
- div_divisor  out  32  divider divisor; registered magnitude
- div_valid  out  1  one-cycle divider start
- div_q  in  32  divider quotient
- div_r  in  32  divider remainder
- div_out_valid  in  1  divider done; may be stuck high

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; out_valid=0; div_valid=0; out_result=0; operand registers=0; lat_cnt=0.
- in_ready = (state==IDLE) && !flush.
- States: IDLE, START, WAIT, DONE.
- IDLE, on accept:
  - Latch op, sign flags s1/s2 (signed ops only; 0 for DIVU/REMU), and magnitudes |src1|, |src2|. |-2^31| = 0x8000_0000 unsigned.
  - src2==0 -> DONE next cycle. Result = 0xFFFF_FFFF for DIV/DIVU, src1 for REM/REMU.
  - Signed op with src1==0x8000_0000 and src2==0xFFFF_FFFF -> DONE next cycle. DIV result = 0x8000_0000; REM result = 0.
  - Otherwise -> START.
- START:
  - div_valid=1 for exactly this cycle; lat_cnt<=1. -> WAIT.
- WAIT:
  - lat_cnt increments each cycle, saturating at 63.
  - Capture when lat_cnt>=DIV_LAT && div_out_valid. div_out_valid with lat_cnt<DIV_LAT is ignored; this covers the stuck-high case after a back-to-back restart.
  - Capture: DIV -> (s1^s2) ? -q : q; DIVU -> q; REM -> s1 ? -r : r; REMU -> r. Two's-complement negation mod 2^32. -> DONE.
- DONE:
  - out_valid=1; out_result stable until the cycle with out_ready=1, then -> IDLE.
  - New requests are accepted only from IDLE, so at least one idle cycle sits between a result and the next start.
- Latency, no stall:
  - Accept in cycle a -> out_valid first high in cycle a+DIV_LAT+2 (a+35).
  - Special cases: out_valid in cycle a+1.
- flush:
  - In any state, next state = IDLE; out_valid<=0; div_valid<=0.
  - An in-flight divider op is abandoned. Its later div_out_valid is ignored outside WAIT or before lat_cnt>=DIV_LAT of a new op.
- Signals outside DONE/START:
  - out_valid is 0 in every state except DONE.
  - div_valid is 0 in every state except START.
- No internal queue: throughput is one op per DIV_LAT+3 cycles minimum.

Decomposition:
- Shared package `mdu_pkg` holds:
  - Op encodings DIV/DIVU/REM/REMU.
  - State enum.
  - DIV_LAT default.
  - Constants INT_MIN = 0x8000_0000 and ALL_ONES.
- The abs/negate helper stays inline.
- The bench instantiates the existing `div`. The controller does not instantiate it; the top-level MDU wires the two together.

Test Plan:
- DIV 100 / -7, out_ready=1 -> div_valid pulse 1 cycle after accept; out_result=0xFFFF_FFF2 (-14) at accept+35; REM same operands -> 2.
- DIVU 0xFFFF_FFFF / 0 and REM -5 / 0 -> divider never started; out_result 0xFFFF_FFFF and 0xFFFF_FFFB at accept+1.
- DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000; REM same -> 0; REMU 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000 via the divider.
- out_ready held low 5 cycles in DONE -> out_valid and out_result stable, in_ready=0; accept only after the handshake cycle.
- flush at WAIT lat_cnt=10, new DIVU 50/7 accepted next cycle -> stale divider completion ignored; result 7 at new accept+35.
- rst_n deasserted mid-WAIT -> all outputs 0 immediately, state IDLE, in_ready=1 after release.
